baccarat_dealer: RTL and testbench

//  Consumer end of the card stream: samples the free-running card code on each

---
 rtl/baccarat_pkg.sv | 23 ++
 rtl/card_score.sv | 11 +
 rtl/baccarat_dealer.sv | 80 ++++++++
 tb/tb_baccarat_dealer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// baccarat_pkg: card/state types and baccarat scoring helpers
package baccarat_pkg;
  localparam int CARD_W = 4;
  localparam int MAX_CARD = 13;
  typedef logic [CARD_W-1:0] card_t;
  localparam card_t CARD_EMPTY = '0;
  typedef enum logic [3:0] {S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_EVAL3, S_D3, S_DONE} state_t;
  function automatic logic card_legal(card_t c);
    return c != CARD_EMPTY && c <= card_t'(MAX_CARD);
  endfunction
  function automatic logic [3:0] card_value(card_t c);
    return (c != CARD_EMPTY && c <= card_t'(9)) ? 4'(c) : 4'd0;
  endfunction
  function automatic logic [3:0] add_mod10(logic [3:0] a, logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= 5'd10 ? 4'(s - 5'd10) : s[3:0];
  endfunction
  function automatic logic banker_draws(logic [3:0] ds, logic [3:0] v);
    return ds <= 4'd2 || (ds == 4'd3 && v != 4'd8) || (ds == 4'd4 && v >= 4'd2 && v <= 4'd7) ||
           (ds == 4'd5 && v >= 4'd4 && v <= 4'd7) || (ds == 4'd6 && v >= 4'd6 && v <= 4'd7);
  endfunction
endpackage

// File: rtl/card_score.sv
// card_score: mod-10 baccarat score of a three-card hand
module card_score
  import baccarat_pkg::*;
(
  input  logic [CARD_W-1:0] c1,
  input  logic [CARD_W-1:0] c2,
  input  logic [CARD_W-1:0] c3,
  output logic [3:0]        score
);
  assign score = add_mod10(add_mod10(card_value(c1), card_value(c2)), card_value(c3));
endmodule

// File: rtl/baccarat_dealer.sv
// baccarat_dealer: deals player/banker hands from a card stream, applies
// third-card rules and reports scores and winner.
module baccarat_dealer
  import baccarat_pkg::*;
(
  input  logic              fast_clk,
  input  logic              rst_n,
  input  logic [CARD_W-1:0] new_card,
  input  logic              step,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [3:0]        pscore,
  output logic [3:0]        dscore,
  output logic              player_win,
  output logic              dealer_win,
  output logic              done,
  output logic              card_err
);
  state_t state, next;
  logic dealing, deal, natural;
  logic [3:0] ds_final;

  card_score u_pscore (.c1(pcard1), .c2(pcard2), .c3(pcard3), .score(pscore));
  card_score u_dscore (.c1(dcard1), .c2(dcard2), .c3(dcard3), .score(dscore));

  assign dealing = state inside {S_P1, S_D1, S_P2, S_D2, S_P3, S_D3};
  assign deal = dealing && step && card_legal(new_card);
  assign natural = pscore >= 4'd8 || dscore >= 4'd8;
  // Finishing from S_D3 must judge with the card being latched on that same edge
  assign ds_final = state == S_D3 ? add_mod10(dscore, card_value(new_card)) : dscore;

  always_comb begin
    next = state;
    case (state)
      S_P1:    next = deal ? S_D1 : S_P1;
      S_D1:    next = deal ? S_P2 : S_D1;
      S_P2:    next = deal ? S_D2 : S_P2;
      S_D2:    next = deal ? S_EVAL : S_D2;
      S_EVAL:  next = natural ? S_DONE : pscore <= 4'd5 ? S_P3 : dscore <= 4'd5 ? S_D3 : S_DONE;
      S_P3:    next = deal ? S_EVAL3 : S_P3;
      S_EVAL3: next = banker_draws(dscore, card_value(pcard3)) ? S_D3 : S_DONE;
      S_D3:    next = deal ? S_DONE : S_D3;
      S_DONE:  next = step ? S_P1 : S_DONE;
      default: next = S_P1;
    endcase
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_P1;
      {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} <= '0;
      {player_win, dealer_win, done, card_err} <= '0;
    end else begin
      state <= next;
      card_err <= dealing && step && !card_legal(new_card);
      if (state == S_DONE && step) begin
        {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} <= '0;
        {player_win, dealer_win, done} <= '0;
      end else if (state != S_DONE && next == S_DONE) begin
        done <= 1'b1;
        player_win <= pscore >= ds_final;
        dealer_win <= ds_final >= pscore;
      end
      if (deal)
        case (state)
          S_P1:    pcard1 <= new_card;
          S_D1:    dcard1 <= new_card;
          S_P2:    pcard2 <= new_card;
          S_D2:    dcard2 <= new_card;
          S_P3:    pcard3 <= new_card;
          S_D3:    dcard3 <= new_card;
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_baccarat_dealer.sv
// tb_baccarat_dealer: directed checks of dealing order, third-card rules and flags
module tb_baccarat_dealer;
  logic fast_clk = 0, rst_n = 0, step = 0;
  logic [3:0] new_card = 0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic player_win, dealer_win, done, card_err;
  int checks = 0, errors = 0;

  baccarat_dealer dut (
    .fast_clk(fast_clk), .rst_n(rst_n), .new_card(new_card), .step(step),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .player_win(player_win),
    .dealer_win(dealer_win), .done(done), .card_err(card_err)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic deal(input logic [3:0] c);
    step = 1;
    new_card = c;
    @(posedge fast_clk);
    @(negedge fast_clk);
    step = 0;
  endtask

  task automatic all_clear(input string tag);
    chk({tag, "_slots"}, int'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 0);
    chk({tag, "_flags"}, int'({player_win, dealer_win, done, card_err}), 0);
    chk({tag, "_scores"}, int'({pscore, dscore}), 0);
  endtask

  initial begin
    repeat (2) @(negedge fast_clk);
    all_clear("reset");
    rst_n = 1;
    @(negedge fast_clk);
    // natural: player 9 vs banker 5
    deal(4); deal(2); deal(5); deal(3);
    chk("nat_pscore", pscore, 9);
    chk("nat_dscore", dscore, 5);
    chk("nat_done_eval", done, 0);
    @(negedge fast_clk);
    chk("nat_done", done, 1);
    chk("nat_pwin", player_win, 1);
    chk("nat_dwin", dealer_win, 0);
    chk("nat_third", int'({pcard3, dcard3}), 0);
    repeat (2) @(negedge fast_clk);
    chk("nat_hold", int'({done, player_win, dealer_win}), 3'b110);
    deal(6);
    all_clear("done_step");
    deal(8);
    chk("after_clear_p1", pcard1, 8);
    // mid-round asynchronous reset
    deal(9); deal(1);
    chk("pre_rst_p2", pcard2, 1);
    #2 rst_n = 0;
    #1 all_clear("mid_rst");
    rst_n = 1;
    @(negedge fast_clk);
    deal(8);
    chk("post_rst_p1", pcard1, 8);
    chk("post_rst_d1", dcard1, 0);
    rst_n = 0;
    @(negedge fast_clk);
    rst_n = 1;
    @(negedge fast_clk);
    // banker third-card table
    deal(2); deal(10); deal(3); deal(6);
    chk("bk_pscore", pscore, 5);
    chk("bk_dscore", dscore, 6);
    @(negedge fast_clk);
    deal(6);
    chk("bk_pcard3", pcard3, 6);
    chk("bk_pscore3", pscore, 1);
    @(negedge fast_clk);
    chk("bk_not_done", done, 0);
    deal(13);
    chk("bk_dcard3", dcard3, 13);
    chk("bk_dscore3", dscore, 6);
    chk("bk_flags", int'({done, player_win, dealer_win}), 3'b101);
    deal(1);
    chk("bk_clear", done, 0);
    // tie, both stand
    deal(2); deal(3); deal(4); deal(3);
    @(negedge fast_clk);
    chk("tie_scores", int'({pscore, dscore}), 8'h66);
    chk("tie_flags", int'({done, player_win, dealer_win}), 3'b111);
    chk("tie_third", int'({pcard3, dcard3}), 0);
    deal(1);
    // player stands on 7, banker 4 draws; step during S_EVAL dropped
    deal(3); deal(2); deal(4); deal(2);
    chk("bd_scores", int'({pscore, dscore}), 8'h74);
    step = 1;
    new_card = 9;
    @(posedge fast_clk);
    @(negedge fast_clk);
    step = 0;
    chk("bd_eval_drop", dcard3, 0);
    chk("bd_eval_err", card_err, 0);
    chk("bd_not_done", done, 0);
    deal(5);
    chk("bd_dcard3", dcard3, 5);
    chk("bd_dscore", dscore, 9);
    chk("bd_flags", int'({done, player_win, dealer_win}), 3'b101);
    deal(1);
    chk("bd_clear", done, 0);
    // illegal cards
    deal(0);
    chk("ill0_err", card_err, 1);
    chk("ill0_p1", pcard1, 0);
    @(negedge fast_clk);
    chk("ill0_pulse", card_err, 0);
    deal(14);
    chk("ill14_err", card_err, 1);
    chk("ill14_p1", pcard1, 0);
    deal(15);
    chk("ill15_err", card_err, 1);
    chk("ill15_p1", pcard1, 0);
    deal(7);
    chk("legal_p1", pcard1, 7);
    chk("legal_d1", dcard1, 0);
    chk("legal_err", card_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
